// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard for load and MDU results.
// Stalls the ID stage on RAW, WAW and MDU-structural hazards.
// Optional feature: define HAZARD_STATS_EN to add the stall_cycles_o counter port.
module hazard_scoreboard #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned MDU_LAT  = 4,
   parameter int unsigned CNT_W    = $clog2(MDU_LAT + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                ID_valid_i,
   input  logic [ADDR_W-1:0]   ID_RS1addr_i,
   input  logic [ADDR_W-1:0]   ID_RS2addr_i,
   input  logic                ID_RS1use_i,
   input  logic                ID_RS2use_i,
   input  logic [ADDR_W-1:0]   ID_RDaddr_i,
   input  logic                ID_RegWrite_i,
   input  logic [1:0]          ID_Kind_i,
   input  logic                flush_i,
   output logic                stall_o,
   output logic [NUM_REGS-1:0] pending_o,
   output logic                mdu_busy_o
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]         stall_cycles_o
`endif
);

   localparam logic [1:0] KindLoad = 2'b01;
   localparam logic [1:0] KindMdu  = 2'b10;

   logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0]               mdu_cnt_q, mdu_cnt_d;

   logic rs1_busy, rs2_busy, rd_busy;
   logic src_hazard, waw_hazard, struct_hazard;
   logic issue, is_load, is_mdu;

   assign is_load = (ID_Kind_i == KindLoad);
   assign is_mdu  = (ID_Kind_i == KindMdu);

   // Look up the counters addressed by ID; register 0 and out-of-range addresses never match.
   always_comb begin
      rs1_busy = 1'b0;
      rs2_busy = 1'b0;
      rd_busy  = 1'b0;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (ID_RS1addr_i == ADDR_W'(r) && cnt_q[r] != '0) rs1_busy = 1'b1;
         if (ID_RS2addr_i == ADDR_W'(r) && cnt_q[r] != '0) rs2_busy = 1'b1;
         if (ID_RDaddr_i  == ADDR_W'(r) && cnt_q[r] != '0) rd_busy  = 1'b1;
      end
   end

   assign src_hazard    = (ID_RS1use_i && rs1_busy) || (ID_RS2use_i && rs2_busy);
   assign waw_hazard    = ID_RegWrite_i && rd_busy;
   assign struct_hazard = is_mdu && (mdu_cnt_q != '0);

   assign stall_o = ID_valid_i && !flush_i && (src_hazard || waw_hazard || struct_hazard);
   assign issue   = ID_valid_i && !flush_i && !stall_o;

   // Next counter values: a new load/MDU entry wins over the per-cycle decrement.
   always_comb begin
      cnt_d = cnt_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (r == 0) begin
            cnt_d[r] = '0;
         end else if (issue && (is_load || is_mdu) && ID_RegWrite_i &&
                      ID_RDaddr_i == ADDR_W'(r)) begin
            cnt_d[r] = is_load ? CNT_W'(LOAD_LAT) : CNT_W'(MDU_LAT);
         end else if (cnt_q[r] != '0) begin
            cnt_d[r] = cnt_q[r] - CNT_W'(1);
         end
      end
   end

   // MDU occupancy: any issued MDU op claims the unit, whether or not it writes a register.
   always_comb begin
      mdu_cnt_d = mdu_cnt_q;
      if (issue && is_mdu) begin
         mdu_cnt_d = CNT_W'(MDU_LAT);
      end else if (mdu_cnt_q != '0) begin
         mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
      end
   end

   // Scoreboard state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         mdu_cnt_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         mdu_cnt_q <= mdu_cnt_d;
      end
   end

   // Decode registered state into status outputs.
   always_comb begin
      pending_o = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         pending_o[r] = (cnt_q[r] != '0);
      end
   end

   assign mdu_busy_o = (mdu_cnt_q != '0);

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cnt_q;

   // Saturating count of edges on which ID was stalled.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
      end else if (stall_o && stall_cnt_q != 32'hFFFF_FFFF) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign stall_cycles_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default parameters.
module tb_hazard_scoreboard;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        ID_valid_i;
   logic [4:0]  ID_RS1addr_i, ID_RS2addr_i, ID_RDaddr_i;
   logic        ID_RS1use_i, ID_RS2use_i, ID_RegWrite_i;
   logic [1:0]  ID_Kind_i;
   logic        flush_i;
   logic        stall_o;
   logic [31:0] pending_o;
   logic        mdu_busy_o;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cycles_o;
`endif

   int checks = 0;
   int errors = 0;

   hazard_scoreboard dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .ID_valid_i    (ID_valid_i),
      .ID_RS1addr_i  (ID_RS1addr_i),
      .ID_RS2addr_i  (ID_RS2addr_i),
      .ID_RS1use_i   (ID_RS1use_i),
      .ID_RS2use_i   (ID_RS2use_i),
      .ID_RDaddr_i   (ID_RDaddr_i),
      .ID_RegWrite_i (ID_RegWrite_i),
      .ID_Kind_i     (ID_Kind_i),
      .flush_i       (flush_i),
      .stall_o       (stall_o),
      .pending_o     (pending_o),
      .mdu_busy_o    (mdu_busy_o)
`ifdef HAZARD_STATS_EN
      ,
      .stall_cycles_o(stall_cycles_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic [1:0] kind, input logic fl);
      ID_valid_i    = v;
      ID_RS1addr_i  = rs1;
      ID_RS1use_i   = u1;
      ID_RS2addr_i  = rs2;
      ID_RS2use_i   = u2;
      ID_RDaddr_i   = rd;
      ID_RegWrite_i = rw;
      ID_Kind_i     = kind;
      flush_i       = fl;
   endtask

   task automatic idle();
      drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0);
   endtask

   // Sample mid-cycle, then advance to just after the next rising edge.
   task automatic smp();
      @(negedge clk_i);
   endtask

   task automatic nxt();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i = 1'b1;
      idle();
      nxt();
      nxt();
      rst_i = 1'b0;
      smp();
      chk("reset_stall", {31'd0, stall_o}, 32'd0);
      chk("reset_pending", pending_o, 32'd0);
      chk("reset_busy", {31'd0, mdu_busy_o}, 32'd0);
`ifdef HAZARD_STATS_EN
      chk("reset_stats", stall_cycles_o, 32'd0);
`endif
      nxt();

      // Load x5, then add x6,x5,x1: one stall cycle.
      drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0);
      smp(); chk("lu_c0_stall", {31'd0, stall_o}, 32'd0);
      nxt();
      drv(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 2'b00, 1'b0);
      smp(); chk("lu_c1_stall", {31'd0, stall_o}, 32'd1);
      chk("lu_c1_pending", pending_o, 32'h0000_0020);
      nxt();
      smp(); chk("lu_c2_stall", {31'd0, stall_o}, 32'd0);
      chk("lu_c2_pending", pending_o, 32'd0);
      nxt();

      // Invalid ID never stalls, even with a hazardous source.
      drv(1'b1, 5'd1, 1'b0, 5'd2, 1'b0, 5'd20, 1'b1, 2'b01, 1'b0);
      nxt();
      drv(1'b0, 5'd20, 1'b1, 5'd20, 1'b1, 5'd21, 1'b1, 2'b00, 1'b0);
      smp(); chk("inv_stall", {31'd0, stall_o}, 32'd0);
      chk("inv_pending", pending_o, 32'h0010_0000);
      nxt();

      // mul x7, then a user of x7: stalls cycles 1-4, issues in cycle 5.
      drv(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 2'b10, 1'b0);
      smp(); chk("mdu_c0_stall", {31'd0, stall_o}, 32'd0);
      nxt();
      drv(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd11, 1'b1, 2'b00, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         smp(); chk("mdu_stall", {31'd0, stall_o}, 32'd1);
         chk("mdu_pending", pending_o, 32'h0000_0080);
         chk("mdu_busy", {31'd0, mdu_busy_o}, 32'd1);
         nxt();
      end
      smp(); chk("mdu_c5_stall", {31'd0, stall_o}, 32'd0);
      chk("mdu_c5_pending", pending_o, 32'd0);
      chk("mdu_c5_busy", {31'd0, mdu_busy_o}, 32'd0);
      nxt();

      // Two independent MDU ops back to back: structural stall.
      drv(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 2'b10, 1'b0);
      nxt();
      drv(1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 5'd10, 1'b1, 2'b10, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         smp(); chk("st_stall", {31'd0, stall_o}, 32'd1);
         chk("st_busy", {31'd0, mdu_busy_o}, 32'd1);
         nxt();
      end
      smp(); chk("st_c5_stall", {31'd0, stall_o}, 32'd0);
      chk("st_c5_busy", {31'd0, mdu_busy_o}, 32'd0);
      nxt();
      idle();
      smp(); chk("st_c6_pending", pending_o, 32'h0000_0400);
      chk("st_c6_busy", {31'd0, mdu_busy_o}, 32'd1);
      for (int c = 0; c < 4; c++) nxt();
      smp(); chk("st_drain_pending", pending_o, 32'd0);
      chk("st_drain_busy", {31'd0, mdu_busy_o}, 32'd0);
      nxt();

      // Load to x0 creates nothing; reading x0 never stalls.
      drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 2'b01, 1'b0);
      nxt();
      drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 2'b00, 1'b0);
      smp(); chk("x0_stall", {31'd0, stall_o}, 32'd0);
      chk("x0_pending", pending_o, 32'd0);
      nxt();

      // RS2 matches a pending load but is not read.
      drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 2'b01, 1'b0);
      nxt();
      drv(1'b1, 5'd1, 1'b1, 5'd13, 1'b0, 5'd14, 1'b1, 2'b00, 1'b0);
      smp(); chk("rs2unused_stall", {31'd0, stall_o}, 32'd0);
      chk("rs2unused_pending", pending_o, 32'h0000_2000);
      nxt();
      idle();
      nxt();

      // WAW: pending MDU on x9, then a load writing x9.
      drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 2'b10, 1'b0);
      nxt();
      drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'b01, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         smp(); chk("waw_stall", {31'd0, stall_o}, 32'd1);
         nxt();
      end
      smp(); chk("waw_c5_stall", {31'd0, stall_o}, 32'd0);
      nxt();
      idle();
      smp(); chk("waw_c6_pending", pending_o, 32'h0000_0200);
      nxt();

      // Flush while hazardous: no stall, no new entry, no MDU claim.
      drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 2'b01, 1'b0);
      nxt();
      drv(1'b1, 5'd15, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 2'b01, 1'b1);
      smp(); chk("fl_stall", {31'd0, stall_o}, 32'd0);
      nxt();
      drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd17, 1'b1, 2'b10, 1'b1);
      smp(); chk("fl_pending", pending_o, 32'd0);
      nxt();
      idle();
      smp(); chk("fl_mdu_pending", pending_o, 32'd0);
      chk("fl_mdu_busy", {31'd0, mdu_busy_o}, 32'd0);
      nxt();

      // Reset in cycle 2 of an MDU stall.
      drv(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 2'b10, 1'b0);
      nxt();
      drv(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd11, 1'b1, 2'b00, 1'b0);
      smp(); chk("rst_c1_stall", {31'd0, stall_o}, 32'd1);
      nxt();
      rst_i = 1'b1;
      smp(); chk("rst_c2_stall", {31'd0, stall_o}, 32'd1);
      nxt();
      rst_i = 1'b0;
      smp(); chk("rst_c3_stall", {31'd0, stall_o}, 32'd0);
      chk("rst_c3_pending", pending_o, 32'd0);
      chk("rst_c3_busy", {31'd0, mdu_busy_o}, 32'd0);
`ifdef HAZARD_STATS_EN
      chk("rst_c3_stats", stall_cycles_o, 32'd0);
`endif
      nxt();

      // Uninterrupted MDU stall: four stall cycles.
      drv(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 2'b10, 1'b0);
      nxt();
      drv(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd11, 1'b1, 2'b00, 1'b0);
      for (int c = 0; c < 4; c++) nxt();
      smp(); chk("full_stall_done", {31'd0, stall_o}, 32'd0);
`ifdef HAZARD_STATS_EN
      chk("stats_four", stall_cycles_o, 32'd4);
`endif
      nxt();
      idle();
      nxt();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
